// File: rtl/frame_shift_register.sv
// frame_shift_register
//   Bidirectional serial shift register with a frame bit counter, used on the
//   VCR decoder serial path. Bits shift in MSB-first (dir=0, left shift) or
//   LSB-first (dir=1, right shift). After FRAME_LEN shifted bits, the shifted
//   word is captured in frame_data and frame_valid pulses on that same edge.
//   A parallel load followed by shifting sends the word out on sout.
//
//   Optional feature macro: FRAME_PARITY_CHECK_EN
//     defined   - even parity is checked over each frame's bits, and the
//                 result is reported on parity_err (1 = odd count of ones)
//     undefined - no parity logic is built, and parity_err is tied to 0
//
// Ports
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   clr          synchronous clear of q, bit_cnt and running parity
//   load         synchronous parallel load of d into q (aborts partial frame)
//   d[N-1:0]     parallel load data
//   shift_en     advance one bit this cycle
//   dir          0 = left shift (sin->q[0]), 1 = right shift (sin->q[N-1])
//   sin          serial input bit
//   q[N-1:0]     live register contents
//   sout         serial output: dir ? q[0] : q[N-1] (combinational)
//   bit_cnt      bits shifted in the current frame, 0..FRAME_LEN-1
//   frame_valid  one-cycle pulse when frame_data is updated
//   frame_data   snapshot of q at frame completion
//   parity_err   parity result of the last completed frame
module frame_shift_register #(
   parameter  int unsigned N         = 32,
   parameter  int unsigned FRAME_LEN = 32,
   localparam int unsigned CNT_W     = $clog2(N + 1)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clr,
   input  logic             load,
   input  logic [N-1:0]     d,
   input  logic             shift_en,
   input  logic             dir,
   input  logic             sin,
   output logic [N-1:0]     q,
   output logic             sout,
   output logic [CNT_W-1:0] bit_cnt,
   output logic             frame_valid,
   output logic [N-1:0]     frame_data,
   output logic             parity_err
);

   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_LEN - 1);

   logic [N-1:0] q_shifted;
   logic         frame_done;

   always_comb begin
      q_shifted = q;
      if (dir) begin
         q_shifted = {sin, q[N-1:1]};
      end else begin
         q_shifted = {q[N-2:0], sin};
      end
   end

   // A frame completes only on a shift edge that is not overridden by clr/load.
   assign frame_done = !clr && !load && shift_en && (bit_cnt == LAST_BIT);

   assign sout = dir ? q[0] : q[N-1];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q           <= '0;
         bit_cnt     <= '0;
         frame_data  <= '0;
         frame_valid <= 1'b0;
      end else begin
         frame_valid <= 1'b0;
         if (clr) begin
            q       <= '0;
            bit_cnt <= '0;
         end else if (load) begin
            q       <= d;
            bit_cnt <= '0;
         end else if (shift_en) begin
            q <= q_shifted;
            if (frame_done) begin
               bit_cnt     <= '0;
               frame_data  <= q_shifted;
               frame_valid <= 1'b1;
            end else begin
               bit_cnt <= bit_cnt + 1'b1;
            end
         end
      end
   end

`ifdef FRAME_PARITY_CHECK_EN
   logic run_par;

   // The completing bit is folded in directly so the result is ready on the
   // same edge as frame_valid.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         run_par    <= 1'b0;
         parity_err <= 1'b0;
      end else begin
         if (clr || load) begin
            run_par <= 1'b0;
         end else if (shift_en) begin
            if (frame_done) begin
               run_par    <= 1'b0;
               parity_err <= run_par ^ sin;
            end else begin
               run_par <= run_par ^ sin;
            end
         end
      end
   end
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_frame_shift_register.sv
module tb_frame_shift_register;

   localparam int unsigned N     = 8;
   localparam int unsigned FL    = 8;
   localparam int unsigned CNT_W = $clog2(N + 1);
`ifdef FRAME_PARITY_CHECK_EN
   localparam logic PAR_EN = 1'b1;
`else
   localparam logic PAR_EN = 1'b0;
`endif

   logic             clk;
   logic             reset_n;
   logic             clr;
   logic             load;
   logic [N-1:0]     d;
   logic             shift_en;
   logic             dir;
   logic             sin;
   logic [N-1:0]     q;
   logic             sout;
   logic [CNT_W-1:0] bit_cnt;
   logic             frame_valid;
   logic [N-1:0]     frame_data;
   logic             parity_err;

   int total = 0;
   int bad   = 0;

   frame_shift_register #(.N(N), .FRAME_LEN(FL)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .clr         (clr),
      .load        (load),
      .d           (d),
      .shift_en    (shift_en),
      .dir         (dir),
      .sin         (sin),
      .q           (q),
      .sout        (sout),
      .bit_cnt     (bit_cnt),
      .frame_valid (frame_valid),
      .frame_data  (frame_data),
      .parity_err  (parity_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock edge; returns 1 time unit after it, away from the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic shift_one(input logic b);
      shift_en = 1'b1;
      sin      = b;
      step();
      shift_en = 1'b0;
   endtask

   // Shift a whole frame; dir=0 sends v MSB-first, dir=1 sends v LSB-first.
   task automatic shift_frame(input logic [7:0] v, input logic dv);
      dir = dv;
      for (int i = 0; i < 8; i++) begin
         shift_one(dv ? v[i] : v[7 - i]);
      end
   endtask

   logic [15:0] pat;
   logic [7:0]  fv_exp;

   initial begin
      reset_n  = 1'b0;
      clr      = 1'b0;
      load     = 1'b0;
      d        = '0;
      shift_en = 1'b0;
      dir      = 1'b0;
      sin      = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_q",    32'(q), 32'h0);
      check("rst_cnt",  32'(bit_cnt), 32'h0);
      check("rst_fd",   32'(frame_data), 32'h0);
      check("rst_fv",   32'(frame_valid), 32'h0);
      check("rst_perr", 32'(parity_err), 32'h0);
      reset_n = 1'b1;
      step();

      // 1: left shift, MSB-first 1,0,1,1,0,0,1,0
      dir = 1'b0;
      shift_one(1); shift_one(0); shift_one(1); shift_one(1);
      shift_one(0); shift_one(0); shift_one(1);
      check("t1_cnt7", 32'(bit_cnt), 32'd7);
      check("t1_fv_early", 32'(frame_valid), 32'h0);
      shift_one(0);
      check("t1_q",   32'(q), 32'hB2);
      check("t1_fd",  32'(frame_data), 32'hB2);
      check("t1_fv",  32'(frame_valid), 32'h1);
      check("t1_cnt", 32'(bit_cnt), 32'h0);
      check("t1_perr", 32'(parity_err), 32'h0);
      step();
      check("t1_fv_drop", 32'(frame_valid), 32'h0);
      check("t1_fd_hold", 32'(frame_data), 32'hB2);

      // 2: right shift, sin 0,1,0,0,1,1,0,1
      dir = 1'b1;
      shift_one(0); shift_one(1); shift_one(0); shift_one(0);
      shift_one(1); shift_one(1); shift_one(0); shift_one(1);
      check("t2_q",  32'(q), 32'hB2);
      check("t2_fd", 32'(frame_data), 32'hB2);
      check("t2_fv", 32'(frame_valid), 32'h1);
      step();
      check("t2_fv_drop", 32'(frame_valid), 32'h0);

      // 3: load A5, shift out MSB-first with sin=0
      dir  = 1'b1;
      load = 1'b1;
      d    = 8'hA5;
      step();
      load = 1'b0;
      check("t3_q_load", 32'(q), 32'hA5);
      check("t3_sout_dir1", 32'(sout), 32'h1);
      dir = 1'b0;
      #1;
      check("t3_sout0", 32'(sout), 32'h1);
      shift_one(0);
      check("t3_sout1", 32'(sout), 32'h0);
      shift_one(0);
      check("t3_sout2", 32'(sout), 32'h1);
      shift_one(0);
      check("t3_sout3", 32'(sout), 32'h0);
      shift_one(0);
      check("t3_q",   32'(q), 32'h50);
      check("t3_cnt", 32'(bit_cnt), 32'd4);
      check("t3_fv",  32'(frame_valid), 32'h0);
      check("t3_fd_kept", 32'(frame_data), 32'hB2);
      dir = 1'b1;
      #1;
      check("t3_sout_q0", 32'(sout), 32'h0);

      // 4: clr, then 16 continuous shifts of C3 then 5A, MSB-first
      clr = 1'b1;
      step();
      clr = 1'b0;
      check("t4_clr_q",   32'(q), 32'h0);
      check("t4_clr_cnt", 32'(bit_cnt), 32'h0);
      check("t4_clr_fd",  32'(frame_data), 32'hB2);
      dir      = 1'b0;
      pat      = 16'hC35A;
      shift_en = 1'b1;
      for (int i = 0; i < 16; i++) begin
         sin = pat[15 - i];
         step();
         fv_exp = (i == 7 || i == 15) ? 8'd1 : 8'd0;
         check("t4_fv",  32'(frame_valid), 32'(fv_exp));
         check("t4_cnt", 32'(bit_cnt), 32'((i + 1) % 8));
         if (i == 7)  check("t4_fd1", 32'(frame_data), 32'hC3);
         if (i == 15) check("t4_fd2", 32'(frame_data), 32'h5A);
      end
      shift_en = 1'b0;
      step();
      check("t4_fv_end", 32'(frame_valid), 32'h0);

      // 5: async reset mid-frame, then clr overriding shift
      clr = 1'b1;
      step();
      clr = 1'b0;
      shift_one(1); shift_one(1); shift_one(1);
      check("t5_q3",   32'(q), 32'h07);
      check("t5_cnt3", 32'(bit_cnt), 32'd3);
      reset_n = 1'b0;
      #1;
      check("t5_rst_q",   32'(q), 32'h0);
      check("t5_rst_cnt", 32'(bit_cnt), 32'h0);
      check("t5_rst_fd",  32'(frame_data), 32'h0);
      #1;
      reset_n = 1'b1;
      shift_one(1); shift_one(1);
      check("t5_q2", 32'(q), 32'h03);
      clr      = 1'b1;
      shift_en = 1'b1;
      sin      = 1'b1;
      step();
      clr      = 1'b0;
      shift_en = 1'b0;
      check("t5_clr_q",   32'(q), 32'h0);
      check("t5_clr_cnt", 32'(bit_cnt), 32'h0);
      check("t5_clr_fv",  32'(frame_valid), 32'h0);

      // 6: parity over frames B3 (odd ones) then B2 (even ones)
      shift_frame(8'hB3, 1'b0);
      check("t6_fd1",   32'(frame_data), 32'hB3);
      check("t6_perr1", 32'(parity_err), 32'(PAR_EN));
      step();
      check("t6_perr1_hold", 32'(parity_err), 32'(PAR_EN));
      shift_frame(8'hB2, 1'b1);
      check("t6_fd2",   32'(frame_data), 32'hB2);
      check("t6_perr2", 32'(parity_err), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
